// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle magnitude comparator: walks operand slices MSB-first, exits early
// on the first unequal slice and falls back to the cascade inputs when all match.
//
// state | meaning
// IDLE  | waiting for start; results and slice_cnt held
// CMP   | comparing slice idx of the latched operands, one slice per edge
module serial_cmp_ctrl #(
  parameter int N = 4,
  parameter int K = 4,
  localparam int W  = N * K,
  localparam int CW = $clog2(K) + 1,
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          Iagtb,
  input  logic          Iaeqb,
  input  logic          Ialtb,
  output logic          busy,
  output logic          done,
  output logic          cgt,
  output logic          ceq,
  output logic          clt,
  output logic [CW-1:0] slice_cnt
);

  typedef enum logic {IDLE, CMP} state_t;

  state_t        state_r, state_nxt;
  logic [IW-1:0] idx_r, idx_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt, cnt_inc;
  logic [W-1:0]  a_r, a_nxt, b_r, b_nxt;
  logic [2:0]    cas_r, cas_nxt;        // {gt, eq, lt}
  logic [2:0]    res_nxt;               // {cgt, ceq, clt}
  logic [CW-1:0] scnt_nxt;
  logic          done_nxt;
  logic [N-1:0]  sa, sb;

  assign busy = (state_r == CMP);

  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    cnt_nxt   = cnt_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    cas_nxt   = cas_r;
    res_nxt   = {cgt, ceq, clt};
    scnt_nxt  = slice_cnt;
    done_nxt  = 1'b0;
    cnt_inc   = cnt_r + CW'(1);
    sa        = a_r[int'(idx_r)*N +: N];
    sb        = b_r[int'(idx_r)*N +: N];
    unique case (state_r)
      IDLE: begin
        if (start) begin
          a_nxt     = a;
          b_nxt     = b;
          cas_nxt   = {Iagtb, Iaeqb, Ialtb};
          idx_nxt   = IW'(K - 1);
          cnt_nxt   = '0;
          state_nxt = CMP;
        end
      end
      CMP: begin
        // abort outranks the comparison: no pulse, results untouched
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = IW'(K - 1);
        end else begin
          cnt_nxt = cnt_inc;
          if (sa == sb && idx_r != '0) begin
            idx_nxt = idx_r - IW'(1);
          end else begin
            if (sa > sb)           res_nxt = 3'b100;
            else if (sa < sb)      res_nxt = 3'b001;
            else if (cas_r[2])     res_nxt = 3'b100;
            else if (cas_r[0])     res_nxt = 3'b001;
            else                   res_nxt = 3'b010;
            scnt_nxt  = cnt_inc;
            done_nxt  = 1'b1;
            idx_nxt   = IW'(K - 1);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= IW'(K - 1);
      cnt_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cas_r     <= '0;
      done      <= 1'b0;
      cgt       <= 1'b0;
      ceq       <= 1'b0;
      clt       <= 1'b0;
      slice_cnt <= '0;
    end else begin
      state_r   <= state_nxt;
      idx_r     <= idx_nxt;
      cnt_r     <= cnt_nxt;
      a_r       <= a_nxt;
      b_r       <= b_nxt;
      cas_r     <= cas_nxt;
      done      <= done_nxt;
      {cgt, ceq, clt} <= res_nxt;
      slice_cnt <= scnt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed plus randomized bench for serial_cmp_ctrl (N=4, K=4) against a
// whole-operand reference model.
module tb_serial_cmp_ctrl;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;
  localparam int CW = $clog2(K) + 1;

  logic          clk, rst_n, start, abort;
  logic [W-1:0]  a, b;
  logic          Iagtb, Iaeqb, Ialtb;
  logic          busy, done, cgt, ceq, clt;
  logic [CW-1:0] slice_cnt;

  int ncmp = 0;
  int nfail = 0;

  serial_cmp_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .Iagtb(Iagtb), .Iaeqb(Iaeqb), .Ialtb(Ialtb),
    .busy(busy), .done(done), .cgt(cgt), .ceq(ceq), .clt(clt),
    .slice_cnt(slice_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the most significant differing bit decides; its slice position
  // gives the number of slices examined. Equal operands defer to the cascade.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] cas,
                       output logic [2:0] res, output int m);
    logic [W-1:0] diff;
    int p;
    diff = av ^ bv;
    p = -1;
    for (int i = 0; i < W; i++) if (diff[i]) p = i;
    if (p < 0) begin
      m = K;
      if (cas[2])      res = 3'b100;
      else if (cas[0]) res = 3'b001;
      else             res = 3'b010;
    end else begin
      m = K - p / N;
      res = (av > bv) ? 3'b100 : 3'b001;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed high.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] cas,
                        input string tag);
    logic [2:0] res;
    int m, edges;
    bit got;
    model(av, bv, cas, res, m);
    a = av; b = bv; {Iagtb, Iaeqb, Ialtb} = cas;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    a = W'($urandom); b = W'($urandom); {Iagtb, Iaeqb, Ialtb} = 3'($urandom);
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    chk({tag, ".done_low"}, 32'(done), 32'd0);
    edges = 0; got = 0;
    while (!got && edges < K + 2) begin
      @(negedge clk);
      edges++;
      if (done) got = 1;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(m));
    chk({tag, ".flags"}, 32'({cgt, ceq, clt}), 32'(res));
    chk({tag, ".slice_cnt"}, 32'(slice_cnt), 32'(m));
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc;
    int mode, sl, gap;

    rst_n = 1'b1; start = 0; abort = 0; a = '0; b = '0;
    Iagtb = 0; Iaeqb = 0; Ialtb = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset.outs", 32'({busy, done, cgt, ceq, clt, slice_cnt}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.hold", 32'({busy, done, cgt, ceq, clt, slice_cnt}), 32'd0);

    run_op(16'h9000, 16'h1FFF, 3'b000, "gt_msb");
    run_op(16'h1234, 16'h1235, 3'b000, "lt_lsb");
    run_op(16'hABCD, 16'hABCD, 3'b010, "eq_casc_eq");
    run_op(16'hABCD, 16'hABCD, 3'b101, "eq_casc_gtlt");
    run_op(16'hABCD, 16'hABCD, 3'b000, "eq_casc_none");
    run_op(16'hABCD, 16'hABCD, 3'b011, "eq_casc_eqlt");

    // start re-asserted mid-run with new operands must be ignored
    @(negedge clk);
    a = 16'h1200; b = 16'h1300; {Iagtb, Iaeqb, Ialtb} = 3'b000; start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; {Iagtb, Iaeqb, Ialtb} = 3'b100;
    @(negedge clk);
    start = 1'b0;
    chk("ignore.busy_e1", 32'({busy, done}), 32'b10);
    @(negedge clk);
    chk("ignore.done_e2", 32'(done), 32'd1);
    chk("ignore.flags", 32'({cgt, ceq, clt}), 32'b001);
    chk("ignore.slice_cnt", 32'(slice_cnt), 32'd2);

    // abort at the first CMP edge
    @(negedge clk);
    a = 16'hF200; b = 16'h1300; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort.no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("abort.flags_held", 32'({cgt, ceq, clt}), 32'b001);
    chk("abort.cnt_held", 32'(slice_cnt), 32'd2);

    // abort in IDLE alongside start still starts
    abort = 1'b1;
    run_op(16'h00F0, 16'h00E0, 3'b000, "start_abort_idle");

    // async reset in the middle of a 4-slice run
    @(negedge clk);
    a = 16'hABCD; b = 16'hABCD; Iaeqb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset.outs", 32'({busy, done, cgt, ceq, clt, slice_cnt}), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("midreset.no_done", 32'({busy, done}), 32'd0);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h1235, 3'b000, "after_reset");

    // randomized, often back-to-back (start in the done cycle)
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      mode = $urandom_range(0, 2);
      sl = $urandom_range(0, K - 1);
      if (mode == 0)      rb = W'($urandom);
      else if (mode == 1) rb = ra;
      else                rb = ra ^ (W'($urandom_range(1, (1 << N) - 1)) << (sl * N));
      rc = 3'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(ra, rb, rc, "rand");
    end

    @(negedge clk);
    chk("final.done_low", 32'(done), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: comparator slice width in bits.
REQ-002 SHALL have parameter K, default 4: number of slices per operand; operand width W = N*K.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel an in-progress comparison.
REQ-007 SHALL have port a  input  W  operand A, unsigned.
REQ-008 SHALL have port b  input  W  operand B, unsigned.
REQ-009 SHALL have ports Iagtb, Iaeqb, Ialtb  input  1 each  cascade inputs from a less-significant stage.
REQ-010 SHALL have port busy  output  1  comparison in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports cgt, ceq, clt  output  1 each  registered result flags.
REQ-013 SHALL have port slice_cnt  output  clog2(K)+1  number of slices examined in the last completed comparison.

Function
REQ-014 SHALL implement states IDLE and CMP; busy SHALL be 1 exactly when state is CMP.
REQ-015 In IDLE, an edge with start=1 SHALL:
- latch a, b and the three cascade inputs;
- set slice index idx=K-1;
- clear the internal examined-slice count;
- enter CMP.
REQ-016 In IDLE with start=0, state, operand registers and outputs SHALL hold.
REQ-017 Each CMP edge SHALL compare slice idx, bits [idx*N+N-1 : idx*N], of the latched operands and increment the examined-slice count.
REQ-018 If the slice of A is greater than the slice of B, the edge SHALL set cgt=1, ceq=0, clt=0 (early exit) and return to IDLE.
REQ-019 If the slice of A is less than the slice of B, the edge SHALL set clt=1, cgt=0, ceq=0 (early exit) and return to IDLE.
REQ-020 If the slices are equal and idx>0, the edge SHALL decrement idx and remain in CMP.
REQ-021 If the slices are equal and idx=0, the edge SHALL set the result from the latched cascade inputs with priority Iagtb > Ialtb > Iaeqb, and SHALL return to IDLE.
REQ-022 If all cascade inputs are 0 in the idx=0 equal case, the result SHALL be ceq=1.
REQ-023 On every deciding edge, slice_cnt SHALL take the total number of slices examined (1..K).
REQ-024 done SHALL be 1 for exactly the cycle following a deciding edge; latency from the start-sampling edge to the deciding edge SHALL be m edges, m = slices examined (min 1, max K).
REQ-025 Exactly one of cgt/ceq/clt SHALL be 1 after the first completion.
REQ-026 cgt/ceq/clt and slice_cnt SHALL hold until the next deciding edge.
REQ-027 start while busy=1 SHALL be ignored; operands and cascade inputs SHALL NOT be re-latched.
REQ-028 abort=1 on a CMP edge SHALL take priority over comparison:
- return to IDLE;
- no done pulse;
- cgt/ceq/clt and slice_cnt unchanged.
REQ-029 abort in IDLE SHALL have no effect; start and abort both high in IDLE SHALL start a comparison.
REQ-030 The block SHALL accept a new start on the edge where done is 1, since state is IDLE in that cycle; back-to-back operations are allowed.

Reset
REQ-031 rst_n=0 SHALL immediately force, without waiting for a clock edge:
- state=IDLE, idx=K-1;
- busy=0, done=0;
- cgt=0, ceq=0, clt=0, slice_cnt=0;
- operand and cascade registers=0.
REQ-032 Reset asserted mid-comparison SHALL discard the operation with no done pulse; operation SHALL resume on the first clock edge after rst_n rises.

Verification (N=4, K=4)
REQ-033 a=16'h9000, b=16'h1FFF, start -> deciding edge 1, cgt=1, slice_cnt=1, done one cycle.
REQ-034 a=16'h1234, b=16'h1235, start -> deciding edge 4, clt=1, slice_cnt=4.
REQ-035 a=b=16'hABCD:
- Iaeqb=1 -> ceq=1 at edge 4;
- Iagtb=1, Ialtb=1 -> cgt=1;
- all cascade inputs 0 -> ceq=1.
REQ-036 a=16'h1200, b=16'h1300:
- start pulsed again at edge 1 with new operands -> ignored, clt=1 at edge 2;
- abort at edge 1 on a fresh run -> busy falls, no done, prior flags held.
REQ-037 rst_n low at edge 2 of a 4-slice run -> all outputs 0 immediately; a new start after release completes normally.
